im_loader: RTL and testbench
============================

Name: im_loader

Overview:
- Writer side of the instruction memory. Receives a program as a byte stream over a valid/ready handshake and assembles the bytes into 32-bit instructions.
- Writes each instruction into a 32-entry instruction store through a synchronous write port, at sequential addresses starting from 0.
- Holds the processor (cpu_hold) for the whole load, then signals completion.
- Sits between the host/serial front end and the instruction memory's write port.

Parameters:
- DEPTH, 32, number of instruction words in the store (address width = clog2(DEPTH) = 5)
- BYTES_PER_WORD, 4, bytes per instruction (fixed at 4; other values unsupported)

Ports:
- clk  in  1  system clock, all state updates on rising edge
- reset  in  1  asynchronous, active-high reset
- start  in  1  one-cycle request to begin a load; sampled only in IDLE
- word_count  in  6  number of words to load, sampled with start; 0 = no load, values >32 clamp to 32
- rx_data  in  8  incoming byte
- rx_valid  in  1  rx_data valid
- rx_ready  out  1  loader accepts a byte this cycle (byte transfer = rx_valid & rx_ready)
- IMWA  out  5  instruction memory write address
- IMWD  out  32  instruction memory write data
- IMWE  out  1  instruction memory write enable, one cycle per word
- cpu_hold  out  1  high while a load is in progress
- busy  out  1  high in any state other than IDLE
- done  out  1  one-cycle pulse when the load completes

Behaviour:
- Reset (asynchronous, any state):
  - FSM goes to IDLE; byte counter, word counter and shift register are cleared.
  - All outputs go low/zero: rx_ready=0, IMWA=0, IMWD=0, IMWE=0, cpu_hold=0, busy=0, done=0.
  - A partial word in flight is discarded; words already written stay in memory.
- State IDLE:
  - rx_ready=0; bytes presented here are not consumed.
  - On start=1: latch the clamped word_count into remaining.
    - remaining=0 → go to DONE.
    - Otherwise clear byte_cnt and word address, go to RECV.
- State RECV:
  - rx_ready=1, cpu_hold=1.
  - On each transfer, shift the byte into the shift register, MSB first: the first byte of a word lands in [31:24], the fourth in [7:0].
  - byte_cnt counts 0..3; on the transfer with byte_cnt=3, go to WRITE.
- State WRITE (exactly one cycle):
  - IMWE=1, IMWA = current word address, IMWD = assembled word.
  - rx_ready=0, so back-to-back bytes stall one cycle.
  - Next cycle: increment the address and decrement remaining. If remaining becomes 0 go to DONE, else go to RECV with byte_cnt=0.
- State DONE (one cycle):
  - done=1, cpu_hold=1, rx_ready=0, then IDLE.
  - cpu_hold drops in the cycle after done.
- Latency: a 4th-byte transfer at edge N produces IMWE high during cycle N+1. The next byte can be accepted at edge N+2 at the earliest.
  - Full-rate load of W words takes 5W+1 cycles from the first accepted byte to the done pulse.
- Address wrap: not possible, because remaining ≤ 32 and the address runs 0..31. A 32-word load ends with a write at IMWA=31.
- start while busy: ignored, with no effect on counters.
- rx_valid deasserted mid-word: the loader waits in RECV indefinitely, keeping partial bytes; there is no timeout.
- IMWD/IMWA hold their last values outside WRITE. Consumers qualify them with IMWE only.
- busy = (state != IDLE). cpu_hold = state in {RECV, WRITE, DONE}.

Test Plan:
- Reset then start with word_count=2; bytes 0x20,0x08,0x00,0x05, 0x00,0x00,0x00,0x00 at full rate → IMWE pulses with IMWA=0/IMWD=0x20080005, then IMWA=1/IMWD=0x00000000; done pulses 11 cycles after the first byte; cpu_hold high throughout.
- word_count=0 with start → done pulse the next cycle; IMWE never asserted; no bytes consumed.
- word_count=40 with 128 random bytes → exactly 32 IMWE pulses, addresses 0..31, data matching the MSB-first packing; the 129th byte is not accepted (rx_ready=0).
- rx_valid toggling 1/0 every cycle plus start pulses during RECV → correct words written; second start has no effect; done appears once.
- Assert reset after 2 bytes of word 1 (word 0 written) → all outputs 0 immediately; new start with word_count=1 writes a fresh word at IMWA=0 with no stale bytes.
- Bytes presented in IDLE with no start → rx_ready stays 0 and no writes occur.

Source files
------------

// File: rtl/im_loader.sv
`default_nettype none
// ============================================================================
// Module   : im_loader
// Purpose  : Instruction-memory writer. Packs an MSB-first byte stream into
//            32-bit words and writes them to sequential addresses from 0,
//            holding the CPU for the duration of the load.
// Revision : 1.0  initial release
// ============================================================================
module im_loader #(
  parameter int DEPTH          = 32,
  parameter int BYTES_PER_WORD = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic [5:0]               word_count,
  input  logic [7:0]               rx_data,
  input  logic                     rx_valid,
  output logic                     rx_ready,
  output logic [$clog2(DEPTH)-1:0] IMWA,
  output logic [31:0]              IMWD,
  output logic                     IMWE,
  output logic                     cpu_hold,
  output logic                     busy,
  output logic                     done
);

  localparam int          ADDR_W      = $clog2(DEPTH);
  localparam logic [5:0]  c_MAX_WORDS = 6'(DEPTH);
  localparam logic [1:0]  c_LAST_BYTE = 2'(BYTES_PER_WORD - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RECV  = 2'd1,
    S_WRITE = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [1:0]          byte_cnt_q, byte_cnt_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [5:0]          remaining_q, remaining_d;
  logic [31:0]         shift_q, shift_d;
  logic [ADDR_W-1:0]   imwa_q, imwa_d;
  logic [31:0]         imwd_q, imwd_d;
  logic [5:0]          w_clamped;
  logic [31:0]         w_next_shift;

  // Requested length saturates at the store depth so the address never wraps.
  assign w_clamped    = (word_count > c_MAX_WORDS) ? c_MAX_WORDS : word_count;
  assign w_next_shift = {shift_q[23:0], rx_data};

  // State and datapath registers; reset discards any partial word.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      byte_cnt_q  <= '0;
      addr_q      <= '0;
      remaining_q <= '0;
      shift_q     <= '0;
      imwa_q      <= '0;
      imwd_q      <= '0;
    end else begin
      state_q     <= state_d;
      byte_cnt_q  <= byte_cnt_d;
      addr_q      <= addr_d;
      remaining_q <= remaining_d;
      shift_q     <= shift_d;
      imwa_q      <= imwa_d;
      imwd_q      <= imwd_d;
    end
  end

  // Next-state logic and per-state strobes.
  always_comb begin
    state_d     = state_q;
    byte_cnt_d  = byte_cnt_q;
    addr_d      = addr_q;
    remaining_d = remaining_q;
    shift_d     = shift_q;
    imwa_d      = imwa_q;
    imwd_d      = imwd_q;
    rx_ready    = 1'b0;
    IMWE        = 1'b0;
    done        = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          remaining_d = w_clamped;
          if (w_clamped == 6'd0) begin
            state_d = S_DONE;
          end else begin
            byte_cnt_d = '0;
            addr_d     = '0;
            state_d    = S_RECV;
          end
        end
      end
      S_RECV: begin
        rx_ready = 1'b1;
        if (rx_valid) begin
          shift_d    = w_next_shift;
          byte_cnt_d = byte_cnt_q + 2'd1;
          if (byte_cnt_q == c_LAST_BYTE) begin
            // Capture the write port here so it holds steady outside WRITE.
            imwa_d  = addr_q;
            imwd_d  = w_next_shift;
            state_d = S_WRITE;
          end
        end
      end
      S_WRITE: begin
        IMWE        = 1'b1;
        addr_d      = addr_q + 1'b1;
        remaining_d = remaining_q - 6'd1;
        byte_cnt_d  = '0;
        state_d     = (remaining_q == 6'd1) ? S_DONE : S_RECV;
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign IMWA     = imwa_q;
  assign IMWD     = imwd_q;
  assign busy     = (state_q != S_IDLE);
  assign cpu_hold = (state_q == S_RECV) || (state_q == S_WRITE) || (state_q == S_DONE);

endmodule
`default_nettype wire

// File: tb/tb_im_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_im_loader
// Purpose  : Self-checking bench for im_loader (table of loads plus directed
//            reset / idle / zero-length sequences).
// Revision : 1.0  initial release
// ============================================================================
module tb_im_loader;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [5:0]  word_count;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic [4:0]  IMWA;
  logic [31:0] IMWD;
  logic        IMWE;
  logic        cpu_hold;
  logic        busy;
  logic        done;

  im_loader #(.DEPTH(32), .BYTES_PER_WORD(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .word_count (word_count),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_ready   (rx_ready),
    .IMWA       (IMWA),
    .IMWD       (IMWD),
    .IMWE       (IMWE),
    .cpu_hold   (cpu_hold),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
    end
  endtask

  // Observation log, sampled on the falling edge when everything is stable.
  logic [4:0]  wa_log[$];
  logic [31:0] wd_log[$];
  int done_cnt  = 0;
  int acc_cnt   = 0;
  int cyc       = 0;
  int first_acc = 0;
  int done_cyc  = 0;
  int hold_err  = 0;

  always @(negedge clk) begin
    cyc++;
    if (IMWE) begin
      wa_log.push_back(IMWA);
      wd_log.push_back(IMWD);
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (rx_valid && rx_ready) begin
      if (acc_cnt == 0) first_acc = cyc;
      acc_cnt++;
    end
    if (cpu_hold !== busy) hold_err++;
  end

  task automatic clear_logs();
    wa_log.delete();
    wd_log.delete();
    done_cnt = 0;
    acc_cnt  = 0;
    hold_err = 0;
  endtask

  logic [7:0] bytes [0:159];

  typedef struct {
    logic [5:0] wc;
    bit         toggle;
    int         exp_words;
  } vec_t;

  vec_t tbl [0:6];

  // One complete load: start pulse, then bytes from the array until done.
  task automatic run_load(input int row, input logic [5:0] wc, input bit toggle, input int exp_words);
    int  idx    = 0;
    int  budget = 0;
    bit  take;
    logic [31:0] exp_word;
    clear_logs();
    @(posedge clk); #1;
    start = 1'b1; word_count = wc;
    @(posedge clk); #1;
    start = 1'b0;
    while (done_cnt == 0 && budget < 3000) begin
      rx_valid   = toggle ? budget[0] : 1'b1;
      rx_data    = bytes[idx];
      start      = toggle && (budget % 7 == 3);
      word_count = 6'd5;
      @(negedge clk);
      take = rx_valid && rx_ready;
      @(posedge clk); #1;
      if (take) idx++;
      budget++;
    end
    start = 1'b0;
    if (budget >= 3000) begin
      checks++; failures++;
      $display("FAIL row%0d_timeout actual=no_done required=done", row);
    end
    // Keep offering bytes after completion; none may be taken.
    rx_valid = 1'b1;
    rx_data  = bytes[idx];
    repeat (3) @(posedge clk);
    #1;
    rx_valid = 1'b0;
    chk($sformatf("row%0d_writes", row), wa_log.size(), exp_words);
    for (int j = 0; j < wa_log.size() && j < exp_words; j++) begin
      exp_word = {bytes[4*j], bytes[4*j+1], bytes[4*j+2], bytes[4*j+3]};
      chk($sformatf("row%0d_addr%0d", row, j), wa_log[j], j);
      chk($sformatf("row%0d_data%0d", row, j), wd_log[j], exp_word);
    end
    chk($sformatf("row%0d_done_cnt", row), done_cnt, 1);
    chk($sformatf("row%0d_bytes", row), acc_cnt, 4 * exp_words);
    chk($sformatf("row%0d_hold", row), hold_err, 0);
    if (!toggle && exp_words > 0)
      chk($sformatf("row%0d_latency", row), done_cyc - first_acc + 1, 5 * exp_words + 1);
  endtask

  initial begin
    int budget;
    reset = 1'b1; start = 1'b0; word_count = '0; rx_data = '0; rx_valid = 1'b0;
    for (int k = 0; k < 160; k++) bytes[k] = 8'($urandom_range(0, 255));
    bytes[0] = 8'h20; bytes[1] = 8'h08; bytes[2] = 8'h00; bytes[3] = 8'h05;
    bytes[4] = 8'h00; bytes[5] = 8'h00; bytes[6] = 8'h00; bytes[7] = 8'h00;

    tbl[0] = '{6'd2,  1'b0, 2};
    tbl[1] = '{6'd0,  1'b0, 0};
    tbl[2] = '{6'd40, 1'b0, 32};
    tbl[3] = '{6'd1,  1'b0, 1};
    tbl[4] = '{6'd3,  1'b1, 3};
    tbl[5] = '{6'd33, 1'b0, 32};
    tbl[6] = '{6'd7,  1'b1, 7};

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    chk("rst_rx_ready", rx_ready, 0);
    chk("rst_imwa", IMWA, 0);
    chk("rst_imwd", IMWD, 0);
    chk("rst_imwe", IMWE, 0);
    chk("rst_cpu_hold", cpu_hold, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    reset = 1'b0;

    // Bytes offered in IDLE without start are ignored.
    @(posedge clk); #1;
    clear_logs();
    rx_valid = 1'b1; rx_data = 8'hA5;
    repeat (5) begin
      @(negedge clk);
      chk("idle_rx_ready", rx_ready, 0);
    end
    @(posedge clk); #1;
    rx_valid = 1'b0;
    chk("idle_writes", wa_log.size(), 0);
    chk("idle_bytes", acc_cnt, 0);

    // Zero-length load: done the cycle after start, then straight back to idle.
    @(posedge clk); #1;
    start = 1'b1; word_count = 6'd0;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    chk("zero_done", done, 1);
    chk("zero_busy", busy, 1);
    chk("zero_hold", cpu_hold, 1);
    chk("zero_imwe", IMWE, 0);
    @(negedge clk);
    chk("zero_done_after", done, 0);
    chk("zero_busy_after", busy, 0);
    chk("zero_hold_after", cpu_hold, 0);

    // Table of complete loads.
    for (int r = 0; r < 7; r++) begin
      run_load(r, tbl[r].wc, tbl[r].toggle, tbl[r].exp_words);
      if (r == 0 && wd_log.size() == 2) begin
        chk("known_word0", wd_log[0], 32'h2008_0005);
        chk("known_word1", wd_log[1], 32'h0000_0000);
      end
    end

    // Reset in the middle of word 1 of a 3-word load.
    clear_logs();
    @(posedge clk); #1;
    start = 1'b1; word_count = 6'd3;
    @(posedge clk); #1;
    start = 1'b0;
    budget = 0;
    rx_valid = 1'b1;
    rx_data  = 8'h11;
    while (acc_cnt < 6 && budget < 200) begin
      rx_data = rx_data + 8'h11;
      @(posedge clk); #1;
      budget++;
    end
    chk("mid_word0_written", wa_log.size(), 1);
    chk("mid_bytes", acc_cnt, 6);
    #1;
    reset = 1'b1;
    #1;
    chk("mid_rst_rx_ready", rx_ready, 0);
    chk("mid_rst_imwa", IMWA, 0);
    chk("mid_rst_imwd", IMWD, 0);
    chk("mid_rst_imwe", IMWE, 0);
    chk("mid_rst_hold", cpu_hold, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_done", done, 0);
    rx_valid = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    run_load(7, 6'd1, 1'b0, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
